rcv_block_p: RTL and testbench

Parametrised UART receive path: the next-generation serial receiver, generalised in data width, bit period and parity mode, with a small receive FIFO in place of a single-entry buffer. It synchronises `serial_in`, detects and validates start bits, and samples data, parity and stop bits mid-bit. Good frames are pushed into a FIFO read by the host through a `data_read` pop strobe. It sits between the serial pin and the register/bus interface.

---
 rtl/rcv_pkg.sv | 35 +++
 rtl/rcv_block_p_fifo.sv | 82 ++++++++
 rtl/rcv_block_p.sv | 187 ++++++++++++++++++
 tb/tb_rcv_block_p.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rcv_pkg.sv
// rcv_pkg
//   Shared types and helpers for the UART receive path.
//   parity_mode_t : parity mode selection for the receiver.
//   rcv_state_t   : receive FSM states.
//   parity_bad()  : parity check for one received frame.
package rcv_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_mode_t;

    // State names carry an S_ prefix so they cannot collide with the
    // PARITY parameter of the receiver.
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START_CHK = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_LOAD      = 3'd5
    } rcv_state_t;

    // data_xor is the XOR of all data bits. Returns 1 when the frame fails
    // the check for the given mode; never fails when parity is disabled.
    function automatic logic parity_bad(parity_mode_t mode, logic data_xor, logic par_bit);
        case (mode)
            PAR_EVEN: return data_xor ^ par_bit;
            PAR_ODD:  return ~(data_xor ^ par_bit);
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rcv_block_p_fifo.sv
// rx_fifo
//   Small synchronous FIFO holding received frames.
//   clk, n_rst : clock, asynchronous active-low reset (memory cleared too)
//   push       : write wdata; accepted when not full, or when full and a
//                pop happens in the same cycle
//   pop        : remove head; ignored when empty
//   wdata      : data to write
//   rdata      : current head (mem[rd_ptr])
//   count      : number of entries held
//   full/empty : status
module rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop && !empty;
        // A full FIFO still takes a write when the head leaves this cycle.
        do_push  = push && (!full || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/rcv_block_p.sv
// rcv_block_p
//   Parametrised UART receiver: synchronises serial_in, validates the start
//   bit, samples data/parity/stop mid-bit and pushes good frames into a FIFO.
//   clk           : system clock
//   n_rst         : asynchronous active-low reset
//   serial_in     : asynchronous serial line, idles high
//   data_read     : FIFO pop strobe (ignored when empty)
//   rx_data       : FIFO head, valid while data_ready
//   data_ready    : FIFO not empty
//   fifo_count    : entries held
//   overrun_error : sticky, a good frame was dropped on a full FIFO; cleared by a pop
//   framing_error : last frame had stop bit 0
//   parity_error  : last frame failed the parity check
module rcv_block_p
    import rcv_pkg::*;
#(
    parameter int           DATA_BITS    = 8,
    parameter int           CLKS_PER_BIT = 10,
    parameter parity_mode_t PARITY       = PAR_NONE,
    parameter int           FIFO_DEPTH   = 4
) (
    input  logic                            clk,
    input  logic                            n_rst,
    input  logic                            serial_in,
    input  logic                            data_read,
    output logic [DATA_BITS-1:0]            rx_data,
    output logic                            data_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
    output logic                            overrun_error,
    output logic                            framing_error,
    output logic                            parity_error
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS+1);
    localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT/2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    logic                 sync1_q, sync2_q, line_prev_q;
    rcv_state_t           state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d, timer_inc;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 framing_q, framing_d;
    logic                 parity_q, parity_d;
    logic                 overrun_q, overrun_d;
    logic                 push;
    logic                 fifo_full;
    logic                 fifo_empty;

    assign timer_inc     = timer_q + TW'(1);
    assign data_ready    = !fifo_empty;
    assign overrun_error = overrun_q;
    assign framing_error = framing_q;
    assign parity_error  = parity_q;

    // Two-flop synchroniser plus one history flop for falling-edge detection.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            line_prev_q <= 1'b1;
        end else begin
            sync1_q     <= serial_in;
            sync2_q     <= sync1_q;
            line_prev_q <= sync2_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        framing_d = framing_q;
        parity_d  = parity_q;
        overrun_d = overrun_q;
        push      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (line_prev_q && !sync2_q) begin
                    framing_d = 1'b0;
                    parity_d  = 1'b0;
                    timer_d   = '0;
                    state_d   = S_START_CHK;
                end
            end
            S_START_CHK: begin
                if (timer_q == HALF_LAST) begin
                    timer_d   = '0;
                    bit_cnt_d = '0;
                    // A line back high at mid-start-bit was only a glitch.
                    state_d   = sync2_q ? S_IDLE : S_DATA;
                end else begin
                    timer_d = timer_inc;
                end
            end
            S_DATA: begin
                if (timer_q == FULL_LAST) begin
                    timer_d = '0;
                    // LSB arrives first, so shift in from the top.
                    shift_d = {sync2_q, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY == PAR_NONE) ? S_STOP : S_PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end else begin
                    timer_d = timer_inc;
                end
            end
            S_PARITY: begin
                if (timer_q == FULL_LAST) begin
                    timer_d  = '0;
                    parity_d = parity_bad(PARITY, ^shift_q, sync2_q);
                    state_d  = S_STOP;
                end else begin
                    timer_d = timer_inc;
                end
            end
            S_STOP: begin
                if (timer_q == FULL_LAST) begin
                    timer_d   = '0;
                    framing_d = !sync2_q;
                    state_d   = S_LOAD;
                end else begin
                    timer_d = timer_inc;
                end
            end
            S_LOAD: begin
                push    = !framing_q && !parity_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                timer_d = '0;
            end
        endcase

        // A pop frees a slot in the same cycle, so a simultaneous push on a
        // full FIFO is not an overrun.
        if (data_read && !fifo_empty) begin
            overrun_d = 1'b0;
        end else if (push && fifo_full) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            framing_q <= 1'b0;
            parity_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            framing_q <= framing_d;
            parity_q  <= parity_d;
            overrun_q <= overrun_d;
        end
    end

    rx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .n_rst (n_rst),
        .push  (push),
        .pop   (data_read),
        .wdata (shift_q),
        .rdata (rx_data),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_rcv_block_p.sv
module tb_rcv_block_p;
    import rcv_pkg::*;

    localparam int C     = 10;
    localparam int DB    = 8;
    localparam int DEPTH = 4;

    logic       clk   = 1'b0;
    logic       n_rst = 1'b0;
    logic       sin0  = 1'b1, sin1 = 1'b1;
    logic       rd0   = 1'b0, rd1  = 1'b0;
    logic [7:0] rx0, rx1;
    logic       rdy0, rdy1;
    logic [2:0] cnt0, cnt1;
    logic       ovr0, ovr1, frm0, frm1, par0, par1;

    always #5 clk = ~clk;

    rcv_block_p #(.DATA_BITS(DB), .CLKS_PER_BIT(C), .PARITY(PAR_NONE), .FIFO_DEPTH(DEPTH)) dut_n (
        .clk(clk), .n_rst(n_rst), .serial_in(sin0), .data_read(rd0),
        .rx_data(rx0), .data_ready(rdy0), .fifo_count(cnt0),
        .overrun_error(ovr0), .framing_error(frm0), .parity_error(par0));

    rcv_block_p #(.DATA_BITS(DB), .CLKS_PER_BIT(C), .PARITY(PAR_ODD), .FIFO_DEPTH(DEPTH)) dut_o (
        .clk(clk), .n_rst(n_rst), .serial_in(sin1), .data_read(rd1),
        .rx_data(rx1), .data_ready(rdy1), .fifo_count(cnt1),
        .overrun_error(ovr1), .framing_error(frm1), .parity_error(par1));

    int n_chk  = 0;
    int n_fail = 0;

    // Behavioural model: one ordered list of stored frames per receiver plus flags.
    logic [7:0] mlist [2][8];
    int         mn    [2] = '{0, 0};
    logic       m_ovr [2] = '{1'b0, 1'b0};
    logic       m_frm [2] = '{1'b0, 1'b0};
    logic       m_par [2] = '{1'b0, 1'b0};

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void m_push(int d, logic [7:0] v);
        mlist[d][mn[d]] = v;
        mn[d]++;
    endfunction

    function automatic void m_pop(int d);
        for (int i = 0; i < 7; i++) mlist[d][i] = mlist[d][i+1];
        mn[d]--;
    endfunction

    function automatic void m_reset_all();
        for (int d = 0; d < 2; d++) begin
            mn[d] = 0; m_ovr[d] = 1'b0; m_frm[d] = 1'b0; m_par[d] = 1'b0;
        end
    endfunction

    task automatic set_pin(int d, logic v);
        if (d == 0) sin0 = v; else sin1 = v;
    endtask

    task automatic set_rd(int d, logic v);
        if (d == 0) rd0 = v; else rd1 = v;
    endtask

    task automatic cmp(int d, logic [7:0] rx, logic rdy, logic [2:0] cnt,
                       logic ovr, logic frm, logic par);
        check($sformatf("d%0d data_ready", d), rdy, mn[d] != 0);
        check($sformatf("d%0d fifo_count", d), cnt, mn[d]);
        if (mn[d] > 0) check($sformatf("d%0d rx_data", d), rx, mlist[d][0]);
        check($sformatf("d%0d overrun_error", d), ovr, m_ovr[d]);
        check($sformatf("d%0d framing_error", d), frm, m_frm[d]);
        check($sformatf("d%0d parity_error", d), par, m_par[d]);
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        cmp(0, rx0, rdy0, cnt0, ovr0, frm0, par0);
        cmp(1, rx1, rdy1, cnt1, ovr1, frm1, par1);
    end

    // Drives one frame starting just after a rising edge F. Detection lands at
    // F+3 (t0); stop sample at E; LOAD resolves at E+1. abort_k > 0 pulls reset
    // at that many edges after F.
    task automatic send(int d, logic [7:0] data, logic pbit, logic stop, int pb,
                        parity_mode_t mode, bit pop_at_load, int abort_k);
        logic b [0:11];
        int   nb, ek, last, idx;
        logic x;
        nb = 1 + DB + pb + 1;
        b[0] = 1'b0;
        for (int i = 0; i < DB; i++) b[1+i] = data[i];
        if (pb != 0) b[1+DB] = pbit;
        b[nb-1] = stop;
        ek   = 3 + C/2 + (DB + 1 + pb) * C;
        last = nb * C + 4;
        set_pin(d, 1'b0);
        for (int k = 1; k <= last; k++) begin
            @(posedge clk); #1;
            if (k == abort_k) begin
                n_rst = 1'b0;
                m_reset_all();
                set_pin(d, 1'b1);
                repeat (2) @(posedge clk);
                #1;
                n_rst = 1'b1;
                return;
            end
            if (k == 3) begin
                m_frm[d] = 1'b0;
                m_par[d] = 1'b0;
            end
            if (pb != 0 && k == ek - C) begin
                x = (^data) ^ pbit;
                m_par[d] = (mode == PAR_ODD) ? (x == 1'b0) : (x == 1'b1);
            end
            if (k == ek) begin
                m_frm[d] = !stop;
                if (pop_at_load) set_rd(d, 1'b1);
            end
            if (k == ek + 1) begin
                if (pop_at_load) begin
                    set_rd(d, 1'b0);
                    if (mn[d] > 0) begin
                        m_pop(d);
                        m_ovr[d] = 1'b0;
                    end
                end
                if (!m_frm[d] && !m_par[d]) begin
                    if (mn[d] < DEPTH) m_push(d, data);
                    else m_ovr[d] = 1'b1;
                end
            end
            idx = k / C;
            set_pin(d, (idx < nb) ? b[idx] : 1'b1);
        end
    endtask

    task automatic glitch(int d, int len);
        set_pin(d, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (k == 3) begin
                m_frm[d] = 1'b0;
                m_par[d] = 1'b0;
            end
            if (k == len) set_pin(d, 1'b1);
        end
    endtask

    task automatic pop(int d);
        set_rd(d, 1'b1);
        @(posedge clk); #1;
        if (mn[d] > 0) begin
            m_pop(d);
            m_ovr[d] = 1'b0;
        end
        set_rd(d, 1'b0);
    endtask

    task automatic pop_expect(int d, logic [7:0] exp);
        check($sformatf("d%0d head before pop", d), (d == 0) ? rx0 : rx1, exp);
        pop(d);
    endtask

    initial begin
        n_rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset rx_data n", rx0, 8'h00);
        check("reset rx_data o", rx1, 8'h00);
        check("reset count n", cnt0, 3'd0);
        n_rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Basic frame
        send(0, 8'hA5, 1'b0, 1'b1, 0, PAR_NONE, 1'b0, 0);
        check("A5 rx_data", rx0, 8'hA5);
        check("A5 count", cnt0, 3'd1);
        pop(0);
        check("A5 ready after pop", rdy0, 1'b0);

        // False start
        glitch(0, 3);
        check("glitch count", cnt0, 3'd0);
        check("glitch framing", frm0, 1'b0);

        // Framing error then recovery
        send(0, 8'h3C, 1'b0, 1'b0, 0, PAR_NONE, 1'b0, 0);
        check("3C framing", frm0, 1'b1);
        check("3C count", cnt0, 3'd0);
        send(0, 8'h11, 1'b0, 1'b1, 0, PAR_NONE, 1'b0, 0);
        check("11 framing cleared", frm0, 1'b0);
        pop_expect(0, 8'h11);

        // Odd parity receiver
        send(1, 8'h01, 1'b1, 1'b1, 1, PAR_ODD, 1'b0, 0);
        check("odd bad parity", par1, 1'b1);
        check("odd bad count", cnt1, 3'd0);
        send(1, 8'h01, 1'b0, 1'b1, 1, PAR_ODD, 1'b0, 0);
        check("odd good parity", par1, 1'b0);
        check("odd good count", cnt1, 3'd1);
        pop_expect(1, 8'h01);

        // Overrun
        for (int i = 1; i <= 5; i++) send(0, 8'(i), 1'b0, 1'b1, 0, PAR_NONE, 1'b0, 0);
        check("overrun count", cnt0, 3'd4);
        check("overrun flag", ovr0, 1'b1);
        pop_expect(0, 8'h01);
        check("overrun cleared by pop", ovr0, 1'b0);
        pop_expect(0, 8'h02);
        pop_expect(0, 8'h03);
        pop_expect(0, 8'h04);
        check("drained ready", rdy0, 1'b0);

        // Full FIFO with a pop during LOAD
        for (int i = 1; i <= 4; i++) send(0, 8'(8'h20 + i), 1'b0, 1'b1, 0, PAR_NONE, 1'b0, 0);
        send(0, 8'h25, 1'b0, 1'b1, 0, PAR_NONE, 1'b1, 0);
        check("push+pop full overrun", ovr0, 1'b0);
        check("push+pop full count", cnt0, 3'd4);
        pop_expect(0, 8'h22);
        pop_expect(0, 8'h23);
        pop_expect(0, 8'h24);
        pop_expect(0, 8'h25);

        // Reset during data bit 4, then a clean frame
        send(0, 8'h55, 1'b0, 1'b1, 0, PAR_NONE, 1'b0, 55);
        check("abort count", cnt0, 3'd0);
        check("abort ready", rdy0, 1'b0);
        check("abort rx_data", rx0, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        send(0, 8'h7E, 1'b0, 1'b1, 0, PAR_NONE, 1'b0, 0);
        check("7E rx_data", rx0, 8'h7E);
        pop(0);
        repeat (3) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
